// File: rtl/key_press_gen.sv
// ---------------------------------------------------------------------------
// key_press_gen
//
// Mechanical key emulator. A one-cycle request makes the block drive an
// active-low key line through three phases:
//   press bounce   : 2*BOUNCE_CNT segments of BOUNCE_PERIOD cycles each,
//                    starting low and alternating low/high
//   hold           : HOLD_CYCLES cycles of steady low
//   release bounce : 2*BOUNCE_CNT segments of BOUNCE_PERIOD cycles each,
//                    starting high and alternating high/low
// Then the line returns high and done pulses for one cycle.
// With BOUNCE_CNT = 0 both bounce phases vanish and the press is a clean
// low pulse of HOLD_CYCLES cycles.
//
// Parameters:
//   BOUNCE_PERIOD  cycles per bounce segment, must be >= 1
//   BOUNCE_CNT     bounce pulses per edge, 0 gives clean edges
//   HOLD_CYCLES    cycles of stable low between bounce phases, must be >= 1
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   sys_rst    in   synchronous reset, active-high
//   press_req  in   one-cycle request for a full press/release
//   key_out    out  emulated key line, active-low, idles high
//   busy       out  high while a press sequence is running
//   done       out  one-cycle pulse in the first idle cycle after a sequence
// ---------------------------------------------------------------------------
module key_press_gen #(
  parameter logic [23:0] BOUNCE_PERIOD = 24'd50000,
  parameter logic [3:0]  BOUNCE_CNT    = 4'd3,
  parameter logic [23:0] HOLD_CYCLES   = 24'd2000000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic press_req,
  output logic key_out,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_BNC = 2'd1,
    HOLD      = 2'd2,
    REL_BNC   = 2'd3
  } state_t;

  // Terminal values of the cycle counter and the segment index. The cycle
  // counter runs 0..LAST within a segment or phase and is reloaded with 0 at
  // every boundary. SEG_IDX_LAST underflows when BOUNCE_CNT is 0, but the
  // bounce states are never entered in that case.
  localparam logic [23:0] SEG_LAST     = BOUNCE_PERIOD - 24'd1;
  localparam logic [23:0] HOLD_LAST    = HOLD_CYCLES - 24'd1;
  localparam logic [4:0]  SEG_IDX_LAST = {BOUNCE_CNT, 1'b0} - 5'd1;
  localparam logic        NO_BOUNCE    = (BOUNCE_CNT == 4'd0);

  state_t      state;
  state_t      state_next;
  logic [23:0] cnt;
  logic [23:0] cnt_next;
  logic [4:0]  seg;
  logic [4:0]  seg_next;
  logic        key_next;
  logic        busy_next;
  logic        done_next;

  // State, counters and all outputs are registered together, so the outputs
  // always describe the state the machine is currently in.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      seg     <= '0;
      key_out <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      seg     <= seg_next;
      key_out <= key_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  // Sequencing. Requests are only looked at in IDLE, which includes the done
  // cycle, so a request arriving in the done cycle starts a new sequence on
  // the next edge while requests during a sequence are simply dropped.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    seg_next   = seg;
    done_next  = 1'b0;

    case (state)
      IDLE: begin
        if (press_req) begin
          cnt_next   = '0;
          seg_next   = '0;
          state_next = NO_BOUNCE ? HOLD : PRESS_BNC;
        end
      end

      PRESS_BNC: begin
        if (cnt == SEG_LAST) begin
          cnt_next = '0;
          if (seg == SEG_IDX_LAST) begin
            seg_next   = '0;
            state_next = HOLD;
          end else begin
            seg_next = seg + 5'd1;
          end
        end else begin
          cnt_next = cnt + 24'd1;
        end
      end

      HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_next = '0;
          seg_next = '0;
          if (NO_BOUNCE) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = REL_BNC;
          end
        end else begin
          cnt_next = cnt + 24'd1;
        end
      end

      REL_BNC: begin
        if (cnt == SEG_LAST) begin
          cnt_next = '0;
          if (seg == SEG_IDX_LAST) begin
            seg_next   = '0;
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            seg_next = seg + 5'd1;
          end
        end else begin
          cnt_next = cnt + 24'd1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        seg_next   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state and segment. Press bounce starts
  // low on even segments, release bounce starts high on even segments, so the
  // line level is just the segment parity (inverted for release).
  always_comb begin
    key_next  = 1'b1;
    busy_next = 1'b1;

    case (state_next)
      IDLE: begin
        key_next  = 1'b1;
        busy_next = 1'b0;
      end
      PRESS_BNC: key_next = seg_next[0];
      HOLD:      key_next = 1'b0;
      REL_BNC:   key_next = ~seg_next[0];
      default: begin
        key_next  = 1'b1;
        busy_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_press_gen.sv
// ---------------------------------------------------------------------------
// tb_key_press_gen
//
// Bench for key_press_gen. Two instances share the clock and stimulus:
//   dut_m : BOUNCE_PERIOD=3, BOUNCE_CNT=2, HOLD_CYCLES=10 (34-cycle press)
//   dut_z : BOUNCE_PERIOD=3, BOUNCE_CNT=0, HOLD_CYCLES=10 (clean 10-cycle press)
// A reference model replays a precomputed per-cycle key waveform for each
// configuration and is compared against both instances every cycle.
// ---------------------------------------------------------------------------
module tb_key_press_gen;

  logic sys_clk;
  logic sys_rst;
  logic press_req;
  logic key_m, busy_m, done_m;
  logic key_z, busy_z, done_z;

  key_press_gen #(
    .BOUNCE_PERIOD(24'd3),
    .BOUNCE_CNT   (4'd2),
    .HOLD_CYCLES  (24'd10)
  ) dut_m (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .press_req(press_req),
    .key_out  (key_m),
    .busy     (busy_m),
    .done     (done_m)
  );

  key_press_gen #(
    .BOUNCE_PERIOD(24'd3),
    .BOUNCE_CNT   (4'd0),
    .HOLD_CYCLES  (24'd10)
  ) dut_z (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .press_req(press_req),
    .key_out  (key_z),
    .busy     (busy_z),
    .done     (done_z)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  typedef struct {
    logic rst;
    logic req;
    logic key;
    logic busy;
    logic done;
  } vec_t;

  vec_t tbl[$];

  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;

  // Reference model: expected key level for every cycle of one press.
  logic seq [2][64];
  int   seq_len [2];
  int   pos [2];
  logic m_key [2];
  logic m_busy [2];
  logic m_done [2];

  // Build the waveform of one press straight from the phase description.
  task automatic buildSeq(input int idx, input int p, input int b, input int h);
    int n;
    n = 0;
    for (int i = 0; i < 2 * b; i++)
      for (int k = 0; k < p; k++) begin
        seq[idx][n] = ((i % 2) == 1) ? 1'b1 : 1'b0;
        n++;
      end
    for (int k = 0; k < h; k++) begin
      seq[idx][n] = 1'b0;
      n++;
    end
    for (int j = 0; j < 2 * b; j++)
      for (int k = 0; k < p; k++) begin
        seq[idx][n] = ((j % 2) == 0) ? 1'b1 : 1'b0;
        n++;
      end
    seq_len[idx] = n;
  endtask

  // Advance the model by one clock edge using the inputs sampled there.
  task automatic modelStep(input logic r, input logic q);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        pos[i]    = 0;
        m_key[i]  = 1'b1;
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
      end else if (m_busy[i]) begin
        if (pos[i] < seq_len[i]) begin
          m_key[i]  = seq[i][pos[i]];
          pos[i]    = pos[i] + 1;
          m_done[i] = 1'b0;
        end else begin
          m_key[i]  = 1'b1;
          m_busy[i] = 1'b0;
          m_done[i] = 1'b1;
        end
      end else begin
        m_done[i] = 1'b0;
        if (q) begin
          m_key[i]  = seq[i][0];
          pos[i]    = 1;
          m_busy[i] = 1'b1;
        end else begin
          m_key[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic cmpBit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic cmpInt(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput();
    cmpBit("m.key",  key_m,  m_key[0]);
    cmpBit("m.busy", busy_m, m_busy[0]);
    cmpBit("m.done", done_m, m_done[0]);
    cmpBit("z.key",  key_z,  m_key[1]);
    cmpBit("z.busy", busy_z, m_busy[1]);
    cmpBit("z.done", done_z, m_done[1]);
  endtask

  // Drive inputs well before the edge, step the model at the edge and
  // compare 1 time unit later.
  task automatic applyStimulus(input logic r, input logic q);
    sys_rst   = r;
    press_req = q;
    @(posedge sys_clk);
    cyc++;
    modelStep(r, q);
    #1;
    checkOutput();
  endtask

  task automatic addRun(input logic r, input logic q, input logic k,
                        input logic b, input logic d, input int n);
    vec_t v;
    v = '{rst: r, req: q, key: k, busy: b, done: d};
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  // One request at c=0, optional extra pulses at ign_a/ign_b, 41 cycles in
  // total; tallies what the instances actually did.
  task automatic runPress(input int ign_a, input int ign_b,
                          output int busy_cnt, output int fall_cnt,
                          output int done_cnt, output int busy_z_cnt);
    logic prev;
    prev       = 1'b1;
    busy_cnt   = 0;
    fall_cnt   = 0;
    done_cnt   = 0;
    busy_z_cnt = 0;
    for (int c = 0; c <= 40; c++) begin
      applyStimulus(1'b0, (c == 0) || (c == ign_a) || (c == ign_b));
      if (busy_m === 1'b1) busy_cnt++;
      if (done_m === 1'b1) done_cnt++;
      if (busy_z === 1'b1) busy_z_cnt++;
      if (prev === 1'b1 && key_m === 1'b0) fall_cnt++;
      prev = key_m;
    end
  endtask

  initial begin
    int bc, fc, dc, bz, k;

    sys_rst   = 1'b1;
    press_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pos[i]    = 0;
      m_key[i]  = 1'b1;
      m_busy[i] = 1'b0;
      m_done[i] = 1'b0;
    end
    buildSeq(0, 3, 2, 10);
    buildSeq(1, 3, 0, 10);

    // Reset with request held, then one full press of dut_m.
    addRun(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3);
    addRun(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    addRun(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    addRun(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    addRun(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3);
    addRun(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    addRun(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3);
    addRun(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10);
    addRun(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3);
    addRun(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    addRun(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3);
    addRun(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    addRun(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    addRun(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3);

    $display("[TB] table phase, %0d rows", tbl.size());
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].rst, tbl[i].req);
      cmpBit($sformatf("tbl[%0d].key", i),  key_m,  tbl[i].key);
      cmpBit($sformatf("tbl[%0d].busy", i), busy_m, tbl[i].busy);
      cmpBit($sformatf("tbl[%0d].done", i), done_m, tbl[i].done);
    end

    $display("[TB] single press");
    runPress(-1, -1, bc, fc, dc, bz);
    cmpInt("single.busy_len", bc, 34);
    cmpInt("single.falls",    fc, 5);
    cmpInt("single.dones",    dc, 1);
    cmpInt("single.z_busy",   bz, 10);

    $display("[TB] requests while busy");
    runPress(5, 20, bc, fc, dc, bz);
    cmpInt("ignore.busy_len", bc, 34);
    cmpInt("ignore.falls",    fc, 5);
    cmpInt("ignore.dones",    dc, 1);

    $display("[TB] request in done cycle");
    applyStimulus(1'b0, 1'b1);
    k = 0;
    while (!m_done[0] && k < 60) begin
      applyStimulus(1'b0, 1'b0);
      k++;
    end
    cmpBit("donecyc.reached", (k < 60) ? 1'b1 : 1'b0, 1'b1);
    cmpBit("donecyc.key_high", key_m, 1'b1);
    runPress(-1, -1, bc, fc, dc, bz);
    cmpInt("donecyc.busy_len", bc, 34);
    cmpInt("donecyc.falls",    fc, 5);
    cmpInt("donecyc.dones",    dc, 1);

    $display("[TB] reset during hold");
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b0);
    cmpBit("rsthold.in_hold_key",  key_m,  1'b0);
    cmpBit("rsthold.in_hold_busy", busy_m, 1'b1);
    applyStimulus(1'b1, 1'b0);
    cmpBit("rsthold.key",  key_m,  1'b1);
    cmpBit("rsthold.busy", busy_m, 1'b0);
    cmpBit("rsthold.done", done_m, 1'b0);
    applyStimulus(1'b0, 1'b0);
    cmpBit("rsthold.no_done", done_m, 1'b0);
    runPress(-1, -1, bc, fc, dc, bz);
    cmpInt("rsthold.busy_len", bc, 34);
    cmpInt("rsthold.falls",    fc, 5);
    cmpInt("rsthold.dones",    dc, 1);

    $display("[TB] request held high");
    for (int i = 0; i < 120; i++) applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0);

    $display("[TB] random phase");
    for (int i = 0; i < 3000; i++)
      applyStimulus(($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
